// File: rtl/uart_bus_responder.sv
// uart_bus_responder: device-side model of the board UART chip.
// It takes CPU writes into a holding register and serialises them on txd (8N1).
// It deserialises rxd into a receive buffer that the CPU reads with rdn.
// It also drives the wrn/rdn handshake flags: tbre, tsre, data_ready and overrun.
module uart_bus_responder #(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wrn,
    input  logic       rdn,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       data_ready,
    output logic       tbre,
    output logic       tsre,
    output logic       overrun,
    output logic       txd,
    input  logic       rxd
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_MID  = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

    // CPU strobe history, used for edge detection
    logic wrn_q, rdn_q;
    logic wr_fall, rd_rise;

    // transmit side
    uart_state_e      tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_idx_q, tx_idx_d;
    logic [7:0]       thr_q, thr_d;
    logic [7:0]       tsr_q, tsr_d;
    logic             tbre_q, tbre_d;
    logic             tsre_q, tsre_d;
    logic             txd_q, txd_d;
    logic             tx_bit_end, tx_load;

    // receive side
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    uart_state_e      rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_idx_q, rx_idx_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rbr_q, rbr_d;
    logic             data_ready_q, data_ready_d;
    logic             overrun_q, overrun_d;
    logic             rx_fall, rx_bit_end, rx_mid, rx_done;

    assign wr_fall    = wrn_q & ~wrn;
    assign rd_rise    = ~rdn_q & rdn;

    assign tx_bit_end = (tx_cnt_q == BIT_LAST);
    // A new byte enters the shifter from idle, or straight out of a stop bit when
    // the holding register is already full, so frames run back to back.
    assign tx_load    = ~tbre_q & ((tx_state_q == ST_IDLE) ||
                                   (tx_state_q == ST_STOP && tx_bit_end));

    assign rx_fall    = rx_prev_q & ~rx_sync_q;
    assign rx_bit_end = (rx_cnt_q == BIT_LAST);
    assign rx_mid     = (rx_cnt_q == BIT_MID);
    assign rx_done    = (rx_state_q == ST_STOP) & rx_bit_end & rx_sync_q;

    // State register for both FSMs, their datapaths and the input synchronisers
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrn_q        <= 1'b1;
            rdn_q        <= 1'b1;
            tx_state_q   <= ST_IDLE;
            tx_cnt_q     <= '0;
            tx_idx_q     <= '0;
            thr_q        <= '0;
            tsr_q        <= '0;
            tbre_q       <= 1'b1;
            tsre_q       <= 1'b1;
            txd_q        <= 1'b1;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= ST_IDLE;
            rx_cnt_q     <= '0;
            rx_idx_q     <= '0;
            rx_shift_q   <= '0;
            rbr_q        <= '0;
            data_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            wrn_q        <= wrn;
            rdn_q        <= rdn;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_idx_q     <= tx_idx_d;
            thr_q        <= thr_d;
            tsr_q        <= tsr_d;
            tbre_q       <= tbre_d;
            tsre_q       <= tsre_d;
            txd_q        <= txd_d;
            rx_meta_q    <= rxd;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_idx_q     <= rx_idx_d;
            rx_shift_q   <= rx_shift_d;
            rbr_q        <= rbr_d;
            data_ready_q <= data_ready_d;
            overrun_q    <= overrun_d;
        end
    end

    // TX next-state: idle -> start -> 8 data bits -> stop -> idle or next start
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            ST_IDLE:  if (!tbre_q) tx_state_d = ST_START;
            ST_START: if (tx_bit_end) tx_state_d = ST_DATA;
            ST_DATA:  if (tx_bit_end && tx_idx_q == 3'd7) tx_state_d = ST_STOP;
            ST_STOP:  if (tx_bit_end) tx_state_d = tbre_q ? ST_IDLE : ST_START;
            default:  tx_state_d = ST_IDLE;
        endcase
    end

    // TX outputs: the holding register, the shifter, the bit timer and the line driver
    always_comb begin
        thr_d    = thr_q;
        tsr_d    = tsr_q;
        tbre_d   = tbre_q;
        tsre_d   = tsre_q;
        txd_d    = txd_q;
        tx_idx_d = tx_idx_q;
        tx_cnt_d = (tx_state_q == ST_IDLE || tx_bit_end) ? '0 : tx_cnt_q + CNT_ONE;

        // A write is accepted only into an empty holding register. It cannot
        // collide with tx_load, because tx_load needs tbre low.
        if (wr_fall && tbre_q) begin
            thr_d  = bus_in;
            tbre_d = 1'b0;
        end

        if (tx_load) begin
            tsr_d  = thr_q;
            tbre_d = 1'b1;
            tsre_d = 1'b0;
            txd_d  = 1'b0;
        end else if (tx_bit_end) begin
            case (tx_state_q)
                ST_START: begin
                    txd_d    = tsr_q[0];
                    tsr_d    = {1'b0, tsr_q[7:1]};
                    tx_idx_d = 3'd0;
                end
                ST_DATA: begin
                    if (tx_idx_q == 3'd7) begin
                        txd_d = 1'b1;
                    end else begin
                        txd_d    = tsr_q[0];
                        tsr_d    = {1'b0, tsr_q[7:1]};
                        tx_idx_d = tx_idx_q + 3'd1;
                    end
                end
                ST_STOP: tsre_d = 1'b1;
                default: ;
            endcase
        end
    end

    // RX next-state: wait for a start edge, check the start bit at mid-bit, take 8 data bits, then the stop bit
    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            ST_IDLE:  if (rx_fall) rx_state_d = ST_START;
            ST_START: if (rx_mid) rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
            ST_DATA:  if (rx_bit_end && rx_idx_q == 3'd7) rx_state_d = ST_STOP;
            ST_STOP:  if (rx_bit_end) rx_state_d = ST_IDLE;
            default:  rx_state_d = ST_IDLE;
        endcase
    end

    // RX outputs: the bit timer, the shifter, the receive buffer and the CPU-visible flags
    always_comb begin
        rx_cnt_d     = rx_cnt_q + CNT_ONE;
        rx_idx_d     = rx_idx_q;
        rx_shift_d   = rx_shift_q;
        rbr_d        = rbr_q;
        data_ready_d = data_ready_q;
        overrun_d    = overrun_q;

        case (rx_state_q)
            ST_IDLE:  rx_cnt_d = '0;
            ST_START: begin
                if (rx_mid) begin
                    rx_cnt_d = '0;
                    rx_idx_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_idx_d   = rx_idx_q + 3'd1;
                end
            end
            ST_STOP:  if (rx_bit_end) rx_cnt_d = '0;
            default:  rx_cnt_d = '0;
        endcase

        // When a read completes in the same cycle as a new byte, the new byte
        // wins. The read has consumed the old byte, so this is not an overrun.
        if (rx_done) begin
            rbr_d        = rx_shift_q;
            data_ready_d = 1'b1;
            overrun_d    = rd_rise ? 1'b0 : (overrun_q | data_ready_q);
        end else if (rd_rise) begin
            data_ready_d = 1'b0;
            overrun_d    = 1'b0;
        end
    end

    assign bus_oe     = ~rdn;
    assign bus_out    = rbr_q;
    assign data_ready = data_ready_q;
    assign overrun    = overrun_q;
    assign tbre       = tbre_q;
    assign tsre       = tsre_q;
    assign txd        = txd_q;

endmodule

// File: doc/uart_bus_responder.md
Name: uart_bus_responder

Overview:
Device-side model of the board's UART chip, i.e. the responder for the CPU's UART bus handshake (wrn, rdn, data_ready, tbre, tsre). It accepts bytes written by the CPU over the shared data bus and serialises them on txd. It also deserialises bytes from rxd and presents them to the CPU on a read strobe. It sits between the CPU's memory/IO bus and the serial pins, and is used both in simulation and on-chip for loopback tests.

Parameters:
CLK_DIV, 16, clock cycles per serial bit (even, >= 4)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
wrn  input  1  CPU write strobe, active low; byte captured on its falling edge
rdn  input  1  CPU read strobe, active low
bus_in  input  8  CPU data bus low byte, write data
bus_out  output  8  read data to CPU bus
bus_oe  output  1  drive-enable for bus_out onto shared bus
data_ready  output  1  received byte available
tbre  output  1  transmit holding register empty
tsre  output  1  transmit shift register empty (line idle)
overrun  output  1  sticky: a received byte replaced an unread byte
txd  output  1  serial transmit line, idle high
rxd  input  1  serial receive line, asynchronous

Behaviour:
- Reset (async, immediate): txd=1, tbre=1, tsre=1, data_ready=0, overrun=0, bus_out=0, THR/TSR/RBR=0, both FSMs to IDLE. Reset mid-frame aborts the frame; txd goes high at once.
- wrn/rdn are registered once (wrn_q, rdn_q). Falling edge = q==1 && current==0. Rising edge = q==0 && current==1.
- Write: on a wrn falling edge with tbre=1: THR<=bus_in, tbre<=0. A wrn falling edge while tbre=0 is ignored, and THR is unchanged.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE with tbre=0: next edge TSR<=THR, tbre<=1, tsre<=0, txd<=0, go to START. When TX is idle, tbre is therefore low for exactly 1 cycle.
  - Each bit holds for CLK_DIV cycles, timed by a bit counter.
  - DATA shifts 8 bits LSB first. STOP drives txd=1.
  - At the end of STOP: if tbre=0, load the next byte directly into START with no idle gap. Otherwise tsre<=1 and go to IDLE.
  - Full frame = 10*CLK_DIV cycles.
- RX path: rxd passes through a 2-flop synchroniser.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE: a synchronised falling edge goes to START.
  - START: sample at CLK_DIV/2. If the line is 1, treat it as a glitch and return to IDLE. Otherwise go to DATA.
  - DATA: sample 8 bits at bit centres, every CLK_DIV cycles, LSB first.
  - STOP: sample the stop bit. If 1: RBR<=shift, data_ready<=1, and overrun<=1 if data_ready was already 1. If 0 (framing error): discard the byte and leave flags unchanged.
  - Then go to IDLE.
- Read: bus_oe = ~rdn (combinational); bus_out = RBR.
  - On an rdn rising edge, data_ready<=0 and overrun<=0.
  - If an rdn rising edge and a byte completion fall in the same cycle: RBR takes the new byte, data_ready stays 1, overrun is not set.
- wrn and rdn may be active together; write and read paths are independent.
- TX and RX run concurrently. Loopback (txd tied to rxd) must round-trip any byte.

Test Plan:
- Reset, then write 0x55 (wrn pulse 2 cycles), CLK_DIV=16 → tbre low exactly 1 cycle; tsre low for 160 cycles; txd reads 0,1,0,1,0,1,0,1,0,1 per 16-cycle bit; then tsre=1.
- Drive rxd frame for 0xA3 at 16 cycles/bit → data_ready rises after the stop-bit sample (~152 cycles after the start edge). Pulse rdn low: bus_oe=1, bus_out=0xA3. On rdn rise: data_ready=0.
- Two writes 0x12 then 0x34, the second issued while the first is shifting → no idle gap between frames; txd matches both frames; a third write issued while tbre=0 is dropped.
- rxd low pulse of 4 cycles (glitch) → no reception, data_ready stays 0. Frame 0x7E with stop bit 0 → discarded, data_ready stays 0.
- Receive 0x11 then 0x22 without reading → data_ready=1, overrun=1, bus_out=0x22. rdn pulse clears both flags.
- Assert rst midway through a 0xF0 transmit → txd=1, tbre=1, tsre=1 immediately. After release, a new write of 0x0F transmits correctly.
